// File: rtl/result_pkg.sv
// Shared types for the result RAM reader and the SW-driven result mux.
package result_pkg;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT,
      COMMIT
   } fetch_state_t;

   localparam int RES_SUMA  = 0;
   localparam int RES_RESTA = 1;
   localparam int RES_MULT  = 2;
   localparam int RES_DIV   = 3;
   localparam int RES_POW   = 4;
   localparam int N_RES     = 5;

   typedef enum logic [2:0] {
      SW_SUMA  = 3'b000,
      SW_RESTA = 3'b001,
      SW_MULT  = 3'b010,
      SW_DIV   = 3'b011,
      SW_POW   = 3'b100
   } sw_sel_t;

   // Unused switch codes fall back to SUMA on the display.
   function automatic logic [2:0] sw_to_res(input logic [2:0] sw);
      return (sw > SW_POW) ? 3'(RES_SUMA) : sw;
   endfunction

endpackage

// File: rtl/result_fetch_refresh_timer.sv
// Idle-time refresh counter; pulses on its last count, absent when REFRESH=0.
module refresh_timer
   import result_pkg::*;
#(
   parameter int unsigned REFRESH = 1000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);

   generate
      if (REFRESH == 0) begin : g_off
         logic unused_tie;
         assign unused_tie = ^{clk, rst_n, clr_i, en_i};
         assign expire_o   = 1'b0;
      end else begin : g_cnt
         localparam int unsigned CW =
            (REFRESH > 1) ? $clog2(REFRESH) : 1;
         localparam logic [CW-1:0] LAST = CW'(REFRESH - 1);

         logic [CW-1:0] cnt_q, cnt_d;

         always_comb begin
            cnt_d = cnt_q;
            if (clr_i) begin
               cnt_d = '0;
            end else if (en_i) begin
               cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               cnt_q <= '0;
            end else begin
               cnt_q <= cnt_d;
            end
         end

         assign expire_o = en_i && (cnt_q == LAST);
      end
   endgenerate

endmodule

// File: rtl/result_fetch.sv
// Sweeps five result words from the data RAM into a shadow bank and
// publishes them atomically to the display-side registers.
module result_fetch
   import result_pkg::*;
#(
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned BASE_ADDR = 2,
   parameter int unsigned RD_LAT    = 1,
   parameter int unsigned REFRESH   = 1000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_gnt,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] suma,
   output logic [DATA_W-1:0] resta,
   output logic [DATA_W-1:0] mult,
   output logic [DATA_W-1:0] div_result,
   output logic [DATA_W-1:0] pow_result,
   output logic              valid,
   output logic              busy,
   output logic              done
);

   localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);
   localparam logic [2:0] IDX_LAST = 3'(N_RES - 1);

   fetch_state_t      state_q, state_d;
   logic [2:0]        idx_q, idx_d;
   logic [1:0]        lat_q, lat_d;
   logic              valid_q, valid_d;
   logic [DATA_W-1:0] shadow_q [N_RES];
   logic [DATA_W-1:0] shadow_d [N_RES];
   logic [DATA_W-1:0] res_q [N_RES];
   logic [DATA_W-1:0] res_d [N_RES];
   logic              launch;
   logic              expire;

   refresh_timer #(
      .REFRESH (REFRESH)
   ) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr_i    (launch),
      .en_i     (state_q == IDLE),
      .expire_o (expire)
   );

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      lat_d    = lat_q;
      valid_d  = valid_q;
      shadow_d = shadow_q;
      res_d    = res_q;
      launch   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start || expire) begin
               launch  = 1'b1;
               idx_d   = '0;
               state_d = REQ;
            end
         end
         REQ: begin
            if (mem_gnt) begin
               lat_d   = '0;
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (lat_q == LAT_LAST) begin
               shadow_d[idx_q] = mem_rdata;
               if (idx_q == IDX_LAST) begin
                  // Load outputs on entry so they appear with done.
                  res_d   = shadow_d;
                  valid_d = 1'b1;
                  state_d = COMMIT;
               end else begin
                  idx_d   = idx_q + 3'd1;
                  state_d = REQ;
               end
            end else begin
               lat_d = lat_q + 2'd1;
            end
         end
         COMMIT: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         lat_q   <= '0;
         valid_q <= 1'b0;
         for (int i = 0; i < N_RES; i++) begin
            shadow_q[i] <= '0;
            res_q[i]    <= '0;
         end
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         lat_q    <= lat_d;
         valid_q  <= valid_d;
         shadow_q <= shadow_d;
         res_q    <= res_d;
      end
   end

   assign mem_req    = (state_q == REQ);
   assign mem_addr   = ADDR_W'(BASE_ADDR) + ADDR_W'(idx_q);
   assign busy       = (state_q != IDLE);
   assign done       = (state_q == COMMIT);
   assign valid      = valid_q;
   assign suma       = res_q[RES_SUMA];
   assign resta      = res_q[RES_RESTA];
   assign mult       = res_q[RES_MULT];
   assign div_result = res_q[RES_DIV];
   assign pow_result = res_q[RES_POW];

endmodule

// File: tb/tb_result_fetch.sv
// Directed bench for result_fetch with a RAM/arbiter model and scoreboard.
module tb_result_fetch;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        start [3];
   logic        gnt   [3];
   wire  [31:0] rdata [3];
   wire         req   [3];
   wire  [7:0]  addr  [3];
   wire  [31:0] r_suma [3];
   wire  [31:0] r_resta [3];
   wire  [31:0] r_mult [3];
   wire  [31:0] r_div [3];
   wire  [31:0] r_pow [3];
   wire         vld [3];
   wire         bsy [3];
   wire         dn  [3];

   logic [31:0]  ram [3][256];
   logic [159:0] exp_q [$];
   int total = 0;
   int bad   = 0;

   result_fetch #(
      .ADDR_W(8), .DATA_W(32), .BASE_ADDR(2),
      .RD_LAT(1), .REFRESH(0)
   ) u_dut0 (
      .clk(clk), .rst_n(rst_n), .start(start[0]),
      .mem_req(req[0]), .mem_addr(addr[0]),
      .mem_gnt(gnt[0]), .mem_rdata(rdata[0]),
      .suma(r_suma[0]), .resta(r_resta[0]),
      .mult(r_mult[0]), .div_result(r_div[0]),
      .pow_result(r_pow[0]), .valid(vld[0]),
      .busy(bsy[0]), .done(dn[0])
   );

   result_fetch #(
      .ADDR_W(8), .DATA_W(32), .BASE_ADDR(2),
      .RD_LAT(1), .REFRESH(20)
   ) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start[1]),
      .mem_req(req[1]), .mem_addr(addr[1]),
      .mem_gnt(gnt[1]), .mem_rdata(rdata[1]),
      .suma(r_suma[1]), .resta(r_resta[1]),
      .mult(r_mult[1]), .div_result(r_div[1]),
      .pow_result(r_pow[1]), .valid(vld[1]),
      .busy(bsy[1]), .done(dn[1])
   );

   result_fetch #(
      .ADDR_W(8), .DATA_W(32), .BASE_ADDR(254),
      .RD_LAT(3), .REFRESH(0)
   ) u_dut2 (
      .clk(clk), .rst_n(rst_n), .start(start[2]),
      .mem_req(req[2]), .mem_addr(addr[2]),
      .mem_gnt(gnt[2]), .mem_rdata(rdata[2]),
      .suma(r_suma[2]), .resta(r_resta[2]),
      .mult(r_mult[2]), .div_result(r_div[2]),
      .pow_result(r_pow[2]), .valid(vld[2]),
      .busy(bsy[2]), .done(dn[2])
   );

   // RAM model: data valid only on the exact cycle L after issue.
   for (genvar k = 0; k < 3; k++) begin : g_mem
      localparam int L = (k == 2) ? 3 : 1;
      logic [31:0] pipe [3];
      always @(posedge clk) begin
         pipe[0] <= (req[k] && gnt[k]) ? ram[k][addr[k]]
                                       : 32'hDEAD_BEEF;
         pipe[1] <= pipe[0];
         pipe[2] <= pipe[1];
      end
      assign rdata[k] = pipe[L-1];
   end

   function automatic logic [159:0] pack5(
      input logic [31:0] a, b, c, d, e);
      return {e, d, c, b, a};
   endfunction

   function automatic logic [159:0] outs(input int k);
      return pack5(r_suma[k], r_resta[k], r_mult[k],
                   r_div[k], r_pow[k]);
   endfunction

   task automatic chk(input string tag,
                      input logic [159:0] obs,
                      input logic [159:0] want);
      total++;
      assert (obs === want) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, want);
      end
   endtask

   task automatic load(input int k, input int base,
                       input logic [159:0] v, input bit push);
      for (int i = 0; i < 5; i++)
         ram[k][(base + i) % 256] = v[i*32 +: 32];
      if (push) exp_q.push_back(v);
   endtask

   task automatic pulse(input int k);
      start[k] = 1'b1;
      @(negedge clk);
      start[k] = 1'b0;
   endtask

   task automatic await_done(input int k, input int lim,
                             inout int cyc, input string tag);
      while (!dn[k] && cyc < lim) begin
         @(negedge clk);
         cyc++;
      end
      chk({tag, "_done_seen"}, 160'(dn[k]), 160'(1));
   endtask

   task automatic sb_check(input int k, input string tag);
      logic [159:0] e;
      chk({tag, "_sb_depth"}, 160'(exp_q.size()), 160'(1));
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk(tag, outs(k), e);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      int n;
      bit held;
      logic [159:0] old;

      rst_n = 1'b0;
      for (int k = 0; k < 3; k++) begin
         start[k] = 1'b0;
         gnt[k]   = 1'b1;
         for (int a = 0; a < 256; a++) ram[k][a] = '0;
      end
      repeat (3) @(negedge clk);

      chk("rst_outs", outs(0), '0);
      chk("rst_flags", {vld[0], bsy[0], dn[0], req[0]}, '0);
      chk("rst_addr", 160'(addr[0]), 160'(2));
      chk("rst_addr_wrap", 160'(addr[2]), 160'(254));
      rst_n = 1'b1;
      @(negedge clk);

      // 1: basic sweep, latency 11
      load(1, 2, pack5(5, 3, 15, 1, 125), 1'b0);
      load(0, 2, pack5(5, 3, 15, 1, 125), 1'b1);
      pulse(0);
      cyc = 1;
      chk("t1_busy", 160'(bsy[0]), 160'(1));
      await_done(0, 100, cyc, "t1");
      chk("t1_latency", 160'(cyc), 160'(11));
      sb_check(0, "t1_res");
      chk("t1_valid", 160'(vld[0]), 160'(1));
      @(negedge clk);
      chk("t1_pulse_end", {dn[0], bsy[0]}, '0);

      // 2: grant withheld on idx=2
      old = outs(0);
      load(0, 2, pack5(7, 8, 9, 10, 11), 1'b1);
      pulse(0);
      cyc = 1;
      while (!(req[0] && addr[0] == 8'd4) && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      chk("t2_reach", 160'(cyc), 160'(5));
      gnt[0] = 1'b0;
      repeat (7) begin
         @(negedge clk);
         cyc++;
         chk("t2_hold", {req[0], addr[0]}, {1'b1, 8'd4});
         chk("t2_old", outs(0), old);
      end
      gnt[0] = 1'b1;
      await_done(0, 100, cyc, "t2");
      chk("t2_latency", 160'(cyc), 160'(18));
      sb_check(0, "t2_res");
      @(negedge clk);

      // 3: start while busy is dropped
      load(0, 2, pack5(21, 22, 23, 24, 25), 1'b1);
      pulse(0);
      cyc = 1;
      @(negedge clk);
      cyc++;
      @(negedge clk);
      cyc++;
      start[0] = 1'b1;
      @(negedge clk);
      cyc++;
      start[0] = 1'b0;
      await_done(0, 100, cyc, "t3");
      chk("t3_latency", 160'(cyc), 160'(11));
      sb_check(0, "t3_res");
      n = 0;
      repeat (30) begin
         @(negedge clk);
         if (dn[0] || bsy[0]) n++;
      end
      chk("t3_no_second", 160'(n), 160'(0));

      // 4: reset during WAIT of idx=3
      load(0, 2, pack5(31, 32, 33, 34, 35), 1'b1);
      pulse(0);
      cyc = 1;
      while (!(req[0] && addr[0] == 8'd5) && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      @(negedge clk);
      chk("t4_in_wait", {bsy[0], req[0]}, {1'b1, 1'b0});
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      chk("t4_rst_outs", outs(0), '0);
      chk("t4_rst_flags", {vld[0], bsy[0], dn[0], req[0]}, '0);
      chk("t4_rst_addr", 160'(addr[0]), 160'(2));
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      load(0, 2, pack5(41, 42, 43, 44, 45), 1'b1);
      pulse(0);
      cyc = 1;
      await_done(0, 100, cyc, "t4");
      chk("t4_latency", 160'(cyc), 160'(11));
      sb_check(0, "t4_res");
      chk("t4_valid", 160'(vld[0]), 160'(1));
      @(negedge clk);

      // 5: automatic refresh sweep
      cyc = 0;
      await_done(1, 100, cyc, "t5a");
      chk("t5_first", outs(1), pack5(5, 3, 15, 1, 125));
      ram[1][4] = 32'd16;
      exp_q.push_back(pack5(5, 3, 16, 1, 125));
      cyc  = 0;
      held = 1'b1;
      do begin
         @(negedge clk);
         cyc++;
         if (!dn[1] && r_mult[1] !== 32'd15) held = 1'b0;
      end while (!dn[1] && cyc < 100);
      chk("t5_atomic", 160'(held), 160'(1));
      chk("t5_done_seen", 160'(dn[1]), 160'(1));
      chk("t5_period", 160'(cyc), 160'(31));
      sb_check(1, "t5_res");

      // 6: RD_LAT=3, base 254 wraps through 0
      load(2, 254, pack5(100, 200, 300, 400, 500), 1'b1);
      pulse(2);
      cyc = 1;
      await_done(2, 100, cyc, "t6");
      chk("t6_latency", 160'(cyc), 160'(21));
      sb_check(2, "t6_res");
      chk("t6_valid", 160'(vld[2]), 160'(1));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
